// File: rtl/pll_clken_gen.sv
// Clock-enable generator behind the PLL: lock qualification, downstream reset sequencing,
// and CHANNELS phase-accumulator (NCO) clock-enable strobes, all on the PLL output clock.
module pll_clken_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_BITS  = 8,
    parameter int LOCK_FILTER = 16,
    parameter int RESET_HOLD  = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pll_lock,
    input  logic [CHANNELS*ACC_WIDTH-1:0]  inc,
    input  logic                           inc_load,
    input  logic                           clr_lost,
    output logic                           sys_rst,
    output logic                           locked,
    output logic                           lock_lost,
    output logic [CHANNELS-1:0]            ce,
    output logic [CHANNELS*PHASE_BITS-1:0] phase
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [1:0] {WAIT_LOCK, FILTER, HOLD, RUN} state_t;

    state_t        state, state_next;
    logic [FW-1:0] filt_cnt, filt_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic          lock_meta, lock_s;
    logic          lost_set;
    logic          run_go;

    // Two-flop synchroniser; pll_lock is asynchronous to clk and used nowhere else.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_next = state;
        filt_next  = filt_cnt;
        hold_next  = hold_cnt;
        lost_set   = 1'b0;
        unique case (state)
            WAIT_LOCK: if (lock_s) begin
                state_next = FILTER;
                filt_next  = FW'(1);
            end
            FILTER: if (!lock_s) begin
                state_next = WAIT_LOCK;
            end else if (filt_cnt == FW'(LOCK_FILTER)) begin
                state_next = HOLD;
                hold_next  = '0;
            end else begin
                filt_next = filt_cnt + 1'b1;
            end
            HOLD: if (!lock_s) begin
                state_next = WAIT_LOCK;
            end else if (hold_cnt == HW'(RESET_HOLD - 1)) begin
                state_next = RUN;
            end else begin
                hold_next = hold_cnt + 1'b1;
            end
            RUN: if (!lock_s) begin
                state_next = WAIT_LOCK;
                lost_set   = 1'b1;
            end
            default: state_next = WAIT_LOCK;
        endcase
    end

    // sys_rst/locked are registered from the next state so they move on the state-change edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            filt_cnt  <= '0;
            hold_cnt  <= '0;
            sys_rst   <= 1'b1;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state    <= state_next;
            filt_cnt <= filt_next;
            hold_cnt <= hold_next;
            sys_rst  <= (state_next != RUN);
            locked   <= (state_next == RUN);
            if (lost_set) begin
                lock_lost <= 1'b1;
            end else if (clr_lost) begin
                lock_lost <= 1'b0;
            end
        end
    end

    // Accumulate only while staying in RUN, so the edge that leaves RUN already clears ce/phase.
    assign run_go = (state == RUN) && (state_next == RUN);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [ACC_WIDTH-1:0] incr;
        logic [ACC_WIDTH-1:0] acc;
        logic [ACC_WIDTH:0]   sum;
        logic                 ce_r;

        assign sum = {1'b0, acc} + {1'b0, incr};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                incr <= '0;
                acc  <= '0;
                ce_r <= 1'b0;
            end else begin
                if (inc_load) begin
                    incr <= inc[i*ACC_WIDTH +: ACC_WIDTH];
                end
                if (run_go) begin
                    acc  <= sum[ACC_WIDTH-1:0];
                    ce_r <= sum[ACC_WIDTH];
                end else begin
                    acc  <= '0;
                    ce_r <= 1'b0;
                end
            end
        end

        assign ce[i]                               = ce_r;
        assign phase[i*PHASE_BITS +: PHASE_BITS] = acc[ACC_WIDTH-1 -: PHASE_BITS];
    end

endmodule
